// File: rtl/mem_dump_tx.sv
// Streams a block of 32-bit memory words out of a UART transmitter (8N1),
// little-endian byte order, with early abort and a completion pulse.
module mem_dump_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int ADR_W        = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [ADR_W-1:0] base_adr,
  input  logic [ADR_W-1:0] word_cnt,
  input  logic             abort,
  output logic             mem_rd_o,
  output logic [ADR_W-1:0] mem_adr_o,
  input  logic [31:0]      mem_dat_i,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    START,
    DATA,
    STOP
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    timer_q;
  logic [2:0]       bit_idx_q;
  logic [1:0]       byte_idx_q;
  logic [31:0]      word_q;
  logic [ADR_W-1:0] adr_q;
  logic [ADR_W-1:0] rem_q;
  logic             abort_q;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;
  logic             rd_q;

  logic [7:0]       cur_byte_d;
  logic [ADR_W-1:0] adr_inc_d;
  logic [ADR_W-1:0] rem_dec_d;
  logic             bit_end_d;
  logic             abort_d;

  assign cur_byte_d = word_q[{byte_idx_q, 3'b000} +: 8];
  assign adr_inc_d  = adr_q + ADR_W'(1);
  assign rem_dec_d  = rem_q - ADR_W'(1);
  assign bit_end_d  = (timer_q == BIT_LAST);
  assign abort_d    = abort_q | abort;

  // Every output is a flop so tx and the strobes never glitch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      adr_q      <= '0;
      rem_q      <= '0;
      abort_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      rd_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          abort_q <= 1'b0;
          if (start) begin
            if (word_cnt != '0) begin
              adr_q   <= base_adr;
              rem_q   <= word_cnt;
              rd_q    <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= READ;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            word_q     <= mem_dat_i;
            byte_idx_q <= '0;
            timer_q    <= '0;
            tx_q       <= 1'b0;
            state_q    <= START;
          end
        end
        START: begin
          abort_q <= abort_d;
          if (bit_end_d) begin
            timer_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= cur_byte_d[0];
            state_q   <= DATA;
          end else begin
            timer_q <= timer_q + CW'(1);
          end
        end
        DATA: begin
          abort_q <= abort_d;
          if (bit_end_d) begin
            timer_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= cur_byte_d[bit_idx_q + 3'd1];
            end
          end else begin
            timer_q <= timer_q + CW'(1);
          end
        end
        STOP: begin
          abort_q <= abort_d;
          if (bit_end_d) begin
            timer_q <= '0;
            // An abort arriving on the very last stop cycle still suppresses done.
            if (abort_d) begin
              abort_q <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else if (byte_idx_q != 2'd3) begin
              byte_idx_q <= byte_idx_q + 2'd1;
              tx_q       <= 1'b0;
              state_q    <= START;
            end else begin
              adr_q <= adr_inc_d;
              rem_q <= rem_dec_d;
              if (rem_dec_d != '0) begin
                rd_q    <= 1'b1;
                state_q <= READ;
              end else begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            end
          end else begin
            timer_q <= timer_q + CW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_rd_o  = rd_q;
  assign mem_adr_o = adr_q;

endmodule
